// File: rtl/key_debounce_pio.sv
// Push-button debouncer with an Avalon-MM slave: debounced state, press edgecapture (W1C), optional irq.
// Optional interrupt logic (irqmask register, irq port) is built only when KEY_DEBOUNCE_PIO_IRQ_EN is defined.
module key_debounce_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] key_n
`ifdef KEY_DEBOUNCE_PIO_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE        = CW'(1);

  logic [WIDTH-1:0] sync_1;
  logic [WIDTH-1:0] sync_2;
  logic [WIDTH-1:0] pressed_sync;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_clear;
  logic [CW-1:0]    count [WIDTH];
  logic             bus_write;

  // Synchronizer resets to 1 so a reset looks like every key released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= '1;
      sync_2 <= '1;
    end else begin
      sync_1 <= key_n;
      sync_2 <= sync_1;
    end
  end

  assign pressed_sync = ~sync_2;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      // Toggle on the edge that completes DEBOUNCE_CYCLES consecutive differing samples.
      assign toggle[gi] = (pressed_sync[gi] != debounced[gi]) && (count[gi] == LAST_COUNT);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          count[gi]     <= '0;
          debounced[gi] <= 1'b0;
        end else if (pressed_sync[gi] == debounced[gi]) begin
          count[gi] <= '0;
        end else if (toggle[gi]) begin
          count[gi]     <= '0;
          debounced[gi] <= ~debounced[gi];
        end else begin
          count[gi] <= count[gi] + ONE;
        end
      end
    end
  endgenerate

  assign press     = toggle & ~debounced;
  assign bus_write = chipselect & ~write_n;

  always_comb begin
    edge_clear = '0;
    if (bus_write && (address == 2'd3)) begin
      edge_clear = writedata[WIDTH-1:0];
    end
  end

  // A press landing on the same edge as a W1C clear stays captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~edge_clear) | press;
    end
  end

`ifdef KEY_DEBOUNCE_PIO_IRQ_EN
  logic [WIDTH-1:0] irq_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (bus_write && (address == 2'd2)) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      irq <= |(edge_capture & irq_mask);
    end
  end
`endif

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[WIDTH-1:0] = debounced;
`ifdef KEY_DEBOUNCE_PIO_IRQ_EN
      2'd2: readdata[WIDTH-1:0] = irq_mask;
`endif
      2'd3: readdata[WIDTH-1:0] = edge_capture;
      default: readdata = '0;
    endcase
  end

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_writedata;
      assign unused_writedata = ^writedata[31:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_key_debounce_pio.sv
// Randomized bench for key_debounce_pio: a run-length reference model feeds an expected queue,
// a separate monitor compares every read cycle.
module tb_key_debounce_pio;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int HL = D + 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  key_n;
`ifdef KEY_DEBOUNCE_PIO_IRQ_EN
  logic          irq;
`endif

  key_debounce_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .key_n      (key_n)
`ifdef KEY_DEBOUNCE_PIO_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic        exp_irq_q[$];

  // Reference model: a level is accepted once the last D synchronized samples
  // (raw samples delayed two edges) all agree and differ from the current state.
  logic [W-1:0] hist [HL];
  logic [W-1:0] m_deb, m_ec, m_mask;
  logic         m_irq;
  logic         cur_rst, cur_cs, cur_wn;
  logic [1:0]   cur_addr;
  logic [31:0]  cur_wd;
  logic [W-1:0] cur_key;

  task automatic model_reset();
    for (int i = 0; i < HL; i++) hist[i] = '0;
    m_deb  = '0;
    m_ec   = '0;
    m_mask = '0;
    m_irq  = 1'b0;
  endtask

  task automatic model_edge();
    logic [W-1:0] new_deb, clr;
    bit same;
    if (!cur_rst) begin
      model_reset();
      return;
    end
    for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ~cur_key;
    new_deb = m_deb;
    for (int b = 0; b < W; b++) begin
      same = 1;
      for (int i = 2; i < HL; i++) if (hist[i][b] != hist[2][b]) same = 0;
      if (same && (hist[2][b] != m_deb[b])) new_deb[b] = hist[2][b];
    end
    clr = (cur_cs && !cur_wn && cur_addr == 2'd3) ? cur_wd[W-1:0] : '0;
`ifdef KEY_DEBOUNCE_PIO_IRQ_EN
    m_irq = |(m_ec & m_mask);
    if (cur_cs && !cur_wn && cur_addr == 2'd2) m_mask = cur_wd[W-1:0];
`else
    m_irq = 1'b0;
`endif
    m_ec  = (m_ec & ~clr) | (new_deb & ~m_deb);
    m_deb = new_deb;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_deb);
      2'd2:    return 32'(m_mask);
      2'd3:    return 32'(m_ec);
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: retire the model for the edge just passed, then drive new inputs.
  task automatic cycle(input logic rst, input logic [W-1:0] k, input logic cs, input logic wn,
                       input logic [1:0] a, input logic [31:0] wd);
    @(negedge clk);
    model_edge();
    reset_n = rst; key_n = k; chipselect = cs; write_n = wn; address = a; writedata = wd;
    cur_rst = rst; cur_key = k; cur_cs = cs; cur_wn = wn; cur_addr = a; cur_wd = wd;
    if (!rst) model_reset();
    if (cs && wn) begin
      exp_q.push_back(model_read(a));
      exp_irq_q.push_back(m_irq);
    end
  endtask

  task automatic rd(input logic [W-1:0] k, input logic [1:0] a);
    cycle(1'b1, k, 1'b1, 1'b1, a, 32'd0);
  endtask

  task automatic wr(input logic [W-1:0] k, input logic [1:0] a, input logic [31:0] d);
    cycle(1'b1, k, 1'b1, 1'b0, a, d);
  endtask

  // Monitor: a read cycle (chipselect with write_n high) is the DUT's output event.
  logic [31:0] exp_rd;
  logic        exp_irq;
  always @(negedge clk) begin
    #2;
    if (chipselect && write_n) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL no_expect t=%0t addr=%0d got=%h", $time, address, readdata);
      end else begin
        exp_rd  = exp_q.pop_front();
        exp_irq = exp_irq_q.pop_front();
        if (readdata !== exp_rd) begin
          bad++;
          $display("FAIL readdata t=%0t addr=%0d got=%h want=%h", $time, address, readdata, exp_rd);
        end
`ifdef KEY_DEBOUNCE_PIO_IRQ_EN
        total++;
        if (irq !== exp_irq) begin
          bad++;
          $display("FAIL irq t=%0t got=%b want=%b", $time, irq, exp_irq);
        end
`endif
      end
    end
  end

  logic [W-1:0] kv;

  initial begin
    reset_n = 1'b0; key_n = '1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    cur_rst = 1'b0; cur_key = '1; cur_cs = 1'b0; cur_wn = 1'b1; cur_addr = '0; cur_wd = '0;
    model_reset();
    kv = '1;

    // Reset with keys released: everything reads zero.
    for (int a = 0; a < 4; a++) cycle(1'b0, kv, 1'b1, 1'b1, 2'(a), 32'd0);
    for (int a = 0; a < 4; a++) rd(kv, 2'(a));

    // Key 0 held: exact acceptance latency visible on per-cycle reads.
    kv = 4'b1110;
    for (int i = 0; i < 10; i++) rd(kv, 2'd0);
    rd(kv, 2'd3);

    // Key 1 glitches shorter than the debounce window.
    for (int r = 0; r < 4; r++) begin
      kv[1] = 1'b0;
      for (int i = 0; i < 3; i++) rd(kv, 2'd0);
      kv[1] = 1'b1;
      for (int i = 0; i < 3; i++) rd(kv, 2'd3);
    end

    // Mask, press key 2, irq, then W1C clears it.
    wr(kv, 2'd3, 32'hF);
    wr(kv, 2'd2, 32'hF);
    rd(kv, 2'd2);
    kv[2] = 1'b0;
    for (int i = 0; i < 9; i++) rd(kv, 2'd3);
    wr(kv, 2'd3, 32'h4);
    for (int i = 0; i < 3; i++) rd(kv, 2'd3);

    // W1C for key 3 lands on the same edge key 3 is accepted.
    kv[3] = 1'b0;
    for (int i = 0; i < 5; i++) rd(kv, 2'd0);
    wr(kv, 2'd3, 32'h8);
    for (int i = 0; i < 3; i++) rd(kv, 2'd3);

    // Release all, then reset mid-count with key 0 held.
    kv = '1;
    for (int i = 0; i < 8; i++) rd(kv, 2'd0);
    wr(kv, 2'd3, 32'hF);
    kv = 4'b1110;
    for (int i = 0; i < 4; i++) rd(kv, 2'd0);
    for (int a = 0; a < 4; a++) cycle(1'b0, kv, 1'b1, 1'b1, 2'(a), 32'd0);
    for (int i = 0; i < 8; i++) rd(kv, 2'd0);
    rd(kv, 2'd3);

    // Random traffic, glitchy keys, occasional reset.
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < W; b++) if ($urandom_range(5, 0) == 0) kv[b] = ~kv[b];
      if ($urandom_range(250, 0) == 0) begin
        for (int i = 0; i < int'($urandom_range(3, 1)); i++)
          cycle(1'b0, kv, 1'b1, 1'b1, 2'($urandom_range(3, 0)), 32'd0);
      end else begin
        cycle(1'b1, kv, 1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) != 0),
              2'($urandom_range(3, 0)), $urandom);
      end
    end

    cycle(1'b1, kv, 1'b0, 1'b1, 2'd0, 32'd0);
    cycle(1'b1, kv, 1'b0, 1'b1, 2'd0, 32'd0);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expect got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
